// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry instruction FIFO feeding a registered decode slot.
// Optional macro DECODE_RV32M_EN enables decoding of the RV32M multiply/divide group.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_ir,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      srcreg1_num,
    output logic [4:0]      srcreg2_num,
    output logic [4:0]      dstreg_num,
    output logic [31:0]     imm,
    output logic [5:0]      alucode,
    output logic [1:0]      aluop1_type,
    output logic [1:0]      aluop2_type,
    output logic            reg_we,
    output logic            is_load,
    output logic            is_store,
    output logic            is_halt,
    output logic            illegal,
    output logic            halted
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2,  ALU_BEQ  = 6'd3;
    localparam logic [5:0] ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5,  ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7;
    localparam logic [5:0] ALU_BGEU = 6'd8,  ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14, ALU_SH   = 6'd15;
    localparam logic [5:0] ALU_SW   = 6'd16, ALU_ADD  = 6'd17, ALU_SUB  = 6'd18, ALU_XOR  = 6'd19;
    localparam logic [5:0] ALU_OR   = 6'd20, ALU_AND  = 6'd21, ALU_SLL  = 6'd22, ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24, ALU_SLT  = 6'd25, ALU_SLTU = 6'd26, ALU_NOP  = 6'd63;
`ifdef DECODE_RV32M_EN
    localparam logic [5:0] ALU_MUL  = 6'd27, ALU_MULH = 6'd28, ALU_MULHSU = 6'd29, ALU_MULHU = 6'd30;
    localparam logic [5:0] ALU_DIV  = 6'd31, ALU_DIVU = 6'd32, ALU_REM    = 6'd33, ALU_REMU  = 6'd34;
`endif
    localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1, OP_TYPE_IMM = 2'd2, OP_TYPE_PC = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111, OPC_JAL   = 7'b1101111, OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [1:0]  t1;
        logic [1:0]  t2;
        logic        we;
        logic        ld;
        logic        st;
        logic        halt;
        logic        ill;
    } dec_t;

    logic [PC_W-1:0] pc_mem_q [DEPTH];
    logic [31:0]     ir_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            out_valid_q, halted_q;
    logic [PC_W-1:0] pc_q;
    dec_t            slot_q, dec_d;

    logic            push, pop;
    logic [31:0]     head_ir;
    logic [PC_W-1:0] head_pc;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            we_c, ill_c;

    assign in_ready = (count_q != FULL);
    // No bypass when full: a pop in the same cycle does not open a slot for the push.
    assign push = in_valid && in_ready && !flush;
    assign pop  = (count_q != '0) && !halted_q && (!out_valid_q || out_ready) && !flush;

    assign head_ir = ir_mem_q[rd_ptr_q];
    assign head_pc = pc_mem_q[rd_ptr_q];
    assign opc = head_ir[6:0];
    assign f3  = head_ir[14:12];
    assign f7  = head_ir[31:25];
    assign rd  = head_ir[11:7];
    assign rs1 = head_ir[19:15];
    assign rs2 = head_ir[24:20];
    assign imm_i = {{20{head_ir[31]}}, head_ir[31:20]};
    assign imm_s = {{20{head_ir[31]}}, head_ir[31:25], head_ir[11:7]};
    assign imm_b = {{19{head_ir[31]}}, head_ir[31], head_ir[7], head_ir[30:25], head_ir[11:8], 1'b0};
    assign imm_u = {head_ir[31:12], 12'b0};
    assign imm_j = {{11{head_ir[31]}}, head_ir[31], head_ir[19:12], head_ir[20], head_ir[30:21], 1'b0};

    always_comb begin
        dec_d = '0;
        we_c  = 1'b0;
        ill_c = 1'b0;
        case (opc)
            OPC_OP: begin
                dec_d.rs1 = rs1; dec_d.rs2 = rs2; dec_d.rd = rd;
                dec_d.t1 = OP_TYPE_REG; dec_d.t2 = OP_TYPE_REG; we_c = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  dec_d.alu = ALU_ADD;
                            3'b001:  dec_d.alu = ALU_SLL;
                            3'b010:  dec_d.alu = ALU_SLT;
                            3'b011:  dec_d.alu = ALU_SLTU;
                            3'b100:  dec_d.alu = ALU_XOR;
                            3'b101:  dec_d.alu = ALU_SRL;
                            3'b110:  dec_d.alu = ALU_OR;
                            default: dec_d.alu = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec_d.alu = ALU_SUB;
                        else if (f3 == 3'b101) dec_d.alu = ALU_SRA;
                        else                   ill_c = 1'b1;
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: begin
                        case (f3)
                            3'b000:  dec_d.alu = ALU_MUL;
                            3'b001:  dec_d.alu = ALU_MULH;
                            3'b010:  dec_d.alu = ALU_MULHSU;
                            3'b011:  dec_d.alu = ALU_MULHU;
                            3'b100:  dec_d.alu = ALU_DIV;
                            3'b101:  dec_d.alu = ALU_DIVU;
                            3'b110:  dec_d.alu = ALU_REM;
                            default: dec_d.alu = ALU_REMU;
                        endcase
                    end
`endif
                    default: ill_c = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_d.rs1 = rs1; dec_d.rd = rd; dec_d.imm = imm_i;
                dec_d.t1 = OP_TYPE_REG; dec_d.t2 = OP_TYPE_IMM; we_c = 1'b1;
                // Shift immediates keep funct7 in imm, so SRAI by 1 reads as 1025.
                case (f3)
                    3'b000: dec_d.alu = ALU_ADD;
                    3'b010: dec_d.alu = ALU_SLT;
                    3'b011: dec_d.alu = ALU_SLTU;
                    3'b100: dec_d.alu = ALU_XOR;
                    3'b110: dec_d.alu = ALU_OR;
                    3'b111: dec_d.alu = ALU_AND;
                    3'b001: begin
                        if (f7 == 7'b0000000) dec_d.alu = ALU_SLL;
                        else                  ill_c = 1'b1;
                    end
                    default: begin
                        if (f7 == 7'b0000000)      dec_d.alu = ALU_SRL;
                        else if (f7 == 7'b0100000) dec_d.alu = ALU_SRA;
                        else                       ill_c = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_d.rd = rd; dec_d.imm = imm_u; dec_d.alu = ALU_LUI;
                dec_d.t1 = OP_TYPE_NONE; dec_d.t2 = OP_TYPE_IMM; we_c = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.rd = rd; dec_d.imm = imm_u; dec_d.alu = ALU_ADD;
                dec_d.t1 = OP_TYPE_IMM; dec_d.t2 = OP_TYPE_PC; we_c = 1'b1;
            end
            OPC_JAL: begin
                dec_d.rd = rd; dec_d.imm = imm_j; dec_d.alu = ALU_JAL;
                dec_d.t1 = OP_TYPE_NONE; dec_d.t2 = OP_TYPE_PC; we_c = 1'b1;
            end
            OPC_JALR: begin
                dec_d.rs1 = rs1; dec_d.rd = rd; dec_d.imm = imm_i; dec_d.alu = ALU_JALR;
                dec_d.t1 = OP_TYPE_REG; dec_d.t2 = OP_TYPE_PC; we_c = 1'b1;
                ill_c = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_d.rs1 = rs1; dec_d.rs2 = rs2; dec_d.imm = imm_b;
                dec_d.t1 = OP_TYPE_REG; dec_d.t2 = OP_TYPE_REG;
                case (f3)
                    3'b000:  dec_d.alu = ALU_BEQ;
                    3'b001:  dec_d.alu = ALU_BNE;
                    3'b100:  dec_d.alu = ALU_BLT;
                    3'b101:  dec_d.alu = ALU_BGE;
                    3'b110:  dec_d.alu = ALU_BLTU;
                    3'b111:  dec_d.alu = ALU_BGEU;
                    default: ill_c = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_d.rs1 = rs1; dec_d.rd = rd; dec_d.imm = imm_i; dec_d.ld = 1'b1;
                dec_d.t1 = OP_TYPE_REG; dec_d.t2 = OP_TYPE_IMM; we_c = 1'b1;
                case (f3)
                    3'b000:  dec_d.alu = ALU_LB;
                    3'b001:  dec_d.alu = ALU_LH;
                    3'b010:  dec_d.alu = ALU_LW;
                    3'b100:  dec_d.alu = ALU_LBU;
                    3'b101:  dec_d.alu = ALU_LHU;
                    default: ill_c = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_d.rs1 = rs1; dec_d.rs2 = rs2; dec_d.imm = imm_s; dec_d.st = 1'b1;
                dec_d.t1 = OP_TYPE_REG; dec_d.t2 = OP_TYPE_IMM;
                case (f3)
                    3'b000:  dec_d.alu = ALU_SB;
                    3'b001:  dec_d.alu = ALU_SH;
                    3'b010:  dec_d.alu = ALU_SW;
                    default: ill_c = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                dec_d.halt = 1'b1;
                dec_d.alu  = ALU_NOP;
            end
            default: ill_c = 1'b1;
        endcase
        dec_d.we = we_c && (rd != 5'd0);
        if (ill_c) begin
            dec_d     = '0;
            dec_d.ill = 1'b1;
            dec_d.alu = ALU_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q] <= in_pc;
            ir_mem_q[wr_ptr_q] <= in_ir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            pc_q        <= '0;
            slot_q      <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pop) begin
                out_valid_q <= 1'b1;
                slot_q      <= dec_d;
                pc_q        <= head_pc;
                if (dec_d.halt) halted_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign halted      = halted_q;
    assign out_pc      = pc_q;
    assign srcreg1_num = slot_q.rs1;
    assign srcreg2_num = slot_q.rs2;
    assign dstreg_num  = slot_q.rd;
    assign imm         = slot_q.imm;
    assign alucode     = slot_q.alu;
    assign aluop1_type = slot_q.t1;
    assign aluop2_type = slot_q.t2;
    assign reg_we      = slot_q.we;
    assign is_load     = slot_q.ld;
    assign is_store    = slot_q.st;
    assign is_halt     = slot_q.halt;
    assign illegal     = slot_q.ill;
endmodule
